// File: rtl/elevator_req_queue.sv
// Elevator call queue: circular FIFO of requested levels with duplicate suppression,
// legality check, flush, and registered per-press outcome pulses.
module elevator_req_queue #(
    parameter int LVL_W    = 2,
    parameter int NUM_LVLS = 4,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pressed_en,
    input  logic [LVL_W-1:0]           pressed_lvl,
    input  logic                       pop,
    input  logic                       flush,
    output logic [LVL_W-1:0]           head_lvl,
    output logic                       head_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       req_added,
    output logic                       req_dup,
    output logic                       req_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [LVL_W:0]   NUM_LVLS_C = (LVL_W+1)'(NUM_LVLS);

    logic [LVL_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count_q;
    logic             added_q;
    logic             dup_q;
    logic             drop_q;

    logic             legal;
    logic             dup_hit;
    logic             pop_eff;
    logic             accept;
    logic             is_full;
    logic [PTR_W-1:0] slot;

    assign is_full = (count_q == DEPTH_C);
    assign legal   = ({1'b0, pressed_lvl} < NUM_LVLS_C);
    assign pop_eff = pop & (count_q != '0);
    assign accept  = pressed_en & legal & ~dup_hit & (~is_full | pop_eff) & ~flush;

    // Only the count_q live entries from head onward may match; stale slots are ignored.
    always_comb begin
        dup_hit = 1'b0;
        slot    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (mem[slot] == pressed_lvl)) begin
                dup_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[tail_ptr] <= pressed_lvl;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
            added_q  <= 1'b0;
            dup_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            added_q <= 1'b0;
            dup_q   <= 1'b0;
            drop_q  <= 1'b0;
            if (flush) begin
                head_ptr <= '0;
                tail_ptr <= '0;
                count_q  <= '0;
                drop_q   <= pressed_en;
            end else begin
                if (accept) begin
                    tail_ptr <= tail_ptr + PTR_W'(1);
                end
                if (pop_eff) begin
                    head_ptr <= head_ptr + PTR_W'(1);
                end
                count_q <= count_q + CNT_W'(accept) - CNT_W'(pop_eff);
                if (pressed_en) begin
                    if (!legal) begin
                        drop_q <= 1'b1;
                    end else if (dup_hit) begin
                        dup_q <= 1'b1;
                    end else if (is_full && !pop_eff) begin
                        drop_q <= 1'b1;
                    end else begin
                        added_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign head_valid = (count_q != '0);
    assign head_lvl   = head_valid ? mem[head_ptr] : '0;
    assign count      = count_q;
    assign full       = is_full;
    assign req_added  = added_q;
    assign req_dup    = dup_q;
    assign req_drop   = drop_q;

endmodule

// File: tb/tb_elevator_req_queue.sv
// Directed bench for elevator_req_queue: vector table on an 8-level instance,
// plus a hand sequence on a 4-level instance for illegal levels and stale slots.
module tb_elevator_req_queue;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       a_pe, a_pop, a_flush;
    logic [2:0] a_lvl;
    logic [2:0] a_hl;
    logic       a_hv, a_full, a_add, a_dup, a_drop;
    logic [2:0] a_cnt;

    logic       b_pe, b_pop, b_flush;
    logic [2:0] b_lvl;
    logic [2:0] b_hl;
    logic       b_hv, b_full, b_add, b_dup, b_drop;
    logic [2:0] b_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    elevator_req_queue #(.LVL_W(3), .NUM_LVLS(8), .DEPTH(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .pressed_en(a_pe), .pressed_lvl(a_lvl),
        .pop(a_pop), .flush(a_flush), .head_lvl(a_hl), .head_valid(a_hv),
        .count(a_cnt), .full(a_full), .req_added(a_add), .req_dup(a_dup),
        .req_drop(a_drop)
    );

    elevator_req_queue #(.LVL_W(3), .NUM_LVLS(4), .DEPTH(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .pressed_en(b_pe), .pressed_lvl(b_lvl),
        .pop(b_pop), .flush(b_flush), .head_lvl(b_hl), .head_valid(b_hv),
        .count(b_cnt), .full(b_full), .req_added(b_add), .req_dup(b_dup),
        .req_drop(b_drop)
    );

    typedef struct {
        logic       rst_n;
        logic       pe;
        logic [2:0] lvl;
        logic       pop;
        logic       flush;
        logic [2:0] e_hl;
        logic       e_hv;
        logic [2:0] e_cnt;
        logic       e_full;
        logic       e_add;
        logic       e_dup;
        logic       e_drop;
    } vec_t;

    localparam int NVEC = 23;
    vec_t tbl [NVEC];

    // Packed observation word: {head_lvl, head_valid, count, full, added, dup, drop}
    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got hl=%0d hv=%0b cnt=%0d full=%0b add/dup/drop=%b, want hl=%0d hv=%0b cnt=%0d full=%0b add/dup/drop=%b",
                     name, act[10:8], act[7], act[6:4], act[3], act[2:0],
                     exp_v[10:8], exp_v[7], exp_v[6:4], exp_v[3], exp_v[2:0]);
        end
    endtask

    task automatic b_step(input string name, input logic pe, input logic [2:0] lvl,
                          input logic pp, input logic fl, input logic [10:0] exp_v);
        @(negedge clk);
        b_pe = pe; b_lvl = lvl; b_pop = pp; b_flush = fl;
        @(posedge clk);
        #1;
        check(name, {b_hl, b_hv, b_cnt, b_full, b_add, b_dup, b_drop}, exp_v);
    endtask

    initial begin
        //          rst pe lvl pop fl |  hl hv cnt full add dup drop
        tbl[0]  = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 3, 0, 0,   0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 2, 0, 0,   2, 1, 1, 0, 1, 0, 0};
        tbl[3]  = '{1, 1, 0, 0, 0,   2, 1, 2, 0, 1, 0, 0};
        tbl[4]  = '{1, 1, 3, 0, 0,   2, 1, 3, 0, 1, 0, 0};
        tbl[5]  = '{1, 1, 3, 0, 0,   2, 1, 3, 0, 0, 1, 0};
        tbl[6]  = '{1, 0, 0, 1, 0,   0, 1, 2, 0, 0, 0, 0};
        tbl[7]  = '{1, 1, 0, 0, 0,   0, 1, 2, 0, 0, 1, 0};
        tbl[8]  = '{1, 1, 1, 0, 0,   0, 1, 3, 0, 1, 0, 0};
        tbl[9]  = '{1, 1, 2, 0, 0,   0, 1, 4, 1, 1, 0, 0};
        tbl[10] = '{1, 1, 1, 0, 0,   0, 1, 4, 1, 0, 1, 0};
        tbl[11] = '{1, 1, 5, 0, 0,   0, 1, 4, 1, 0, 0, 1};
        tbl[12] = '{1, 1, 0, 1, 0,   3, 1, 3, 0, 0, 1, 0};
        tbl[13] = '{1, 1, 4, 1, 0,   1, 1, 3, 0, 1, 0, 0};
        tbl[14] = '{1, 1, 6, 0, 0,   1, 1, 4, 1, 1, 0, 0};
        tbl[15] = '{1, 1, 7, 1, 0,   2, 1, 4, 1, 1, 0, 0};
        tbl[16] = '{1, 1, 3, 1, 1,   0, 0, 0, 0, 0, 0, 1};
        tbl[17] = '{1, 1, 3, 0, 0,   3, 1, 1, 0, 1, 0, 0};
        tbl[18] = '{1, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0};
        tbl[19] = '{1, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0};
        tbl[20] = '{1, 1, 7, 0, 0,   7, 1, 1, 0, 1, 0, 0};
        tbl[21] = '{0, 1, 2, 0, 0,   0, 0, 0, 0, 0, 0, 0};
        tbl[22] = '{1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0};

        rst_n = 1'b0;
        a_pe = 1'b0; a_lvl = '0; a_pop = 1'b0; a_flush = 1'b0;
        b_pe = 1'b0; b_lvl = '0; b_pop = 1'b0; b_flush = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rst_n   = tbl[i].rst_n;
            a_pe    = tbl[i].pe;
            a_lvl   = tbl[i].lvl;
            a_pop   = tbl[i].pop;
            a_flush = tbl[i].flush;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {a_hl, a_hv, a_cnt, a_full, a_add, a_dup, a_drop},
                  {tbl[i].e_hl, tbl[i].e_hv, tbl[i].e_cnt, tbl[i].e_full,
                   tbl[i].e_add, tbl[i].e_dup, tbl[i].e_drop});
        end

        @(negedge clk);
        a_pe = 1'b0; a_pop = 1'b0; a_flush = 1'b0;

        // 4-level instance: level boundary, empty pop, stale-slot match, flush with pop
        b_step("b_illegal6",  1'b1, 3'd6, 1'b0, 1'b0, {3'd0, 1'b0, 3'd0, 1'b0, 3'b001});
        b_step("b_illegal4",  1'b1, 3'd4, 1'b0, 1'b0, {3'd0, 1'b0, 3'd0, 1'b0, 3'b001});
        b_step("b_legal3",    1'b1, 3'd3, 1'b0, 1'b0, {3'd3, 1'b1, 3'd1, 1'b0, 3'b100});
        b_step("b_dup3",      1'b1, 3'd3, 1'b0, 1'b0, {3'd3, 1'b1, 3'd1, 1'b0, 3'b010});
        b_step("b_pop",       1'b0, 3'd0, 1'b1, 1'b0, {3'd0, 1'b0, 3'd0, 1'b0, 3'b000});
        b_step("b_pop_empty", 1'b0, 3'd0, 1'b1, 1'b0, {3'd0, 1'b0, 3'd0, 1'b0, 3'b000});
        b_step("b_stale3",    1'b1, 3'd3, 1'b0, 1'b0, {3'd3, 1'b1, 3'd1, 1'b0, 3'b100});
        b_step("b_flush",     1'b1, 3'd3, 1'b1, 1'b1, {3'd0, 1'b0, 3'd0, 1'b0, 3'b001});
        b_step("b_idle",      1'b0, 3'd0, 1'b0, 1'b0, {3'd0, 1'b0, 3'd0, 1'b0, 3'b000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/elevator_req_queue.md
ELEVATOR_REQ_QUEUE -- requirements
Module: elevator_req_queue

Interface
REQ-001 SHALL provide parameter LVL_W, default 2, bit width of one level number.
REQ-002 SHALL provide parameter NUM_LVLS, default 4, number of served levels (legal levels 0..NUM_LVLS-1, NUM_LVLS <= 2**LVL_W).
REQ-003 SHALL provide parameter DEPTH, default 4, number of queue entries (power of two, >= 2).
REQ-004 SHALL have one clock; reset is synchronous and active-low; ports are named clk and rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 pressed_en  input  1  a level button is pressed this cycle.
REQ-008 pressed_lvl  input  LVL_W  level of the pressed button.
REQ-009 pop  input  1  head level served; remove head entry.
REQ-010 flush  input  1  discard all queued entries (emergency stop).
REQ-011 head_lvl  output  LVL_W  level in the oldest entry; 0 when empty.
REQ-012 head_valid  output  1  queue holds at least one entry.
REQ-013 count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-014 full  output  1  count == DEPTH.
REQ-015 req_added  output  1  registered pulse: previous-cycle press was enqueued.
REQ-016 req_dup  output  1  registered pulse: previous-cycle press suppressed as duplicate.
REQ-017 req_drop  output  1  registered pulse: previous-cycle press rejected (full or illegal level).

Function
REQ-018 Storage SHALL be a circular buffer of DEPTH entries, LVL_W bits each, with head pointer, tail pointer and count registers; pointers wrap from DEPTH-1 to 0.
REQ-019 Duplicate check SHALL compare pressed_lvl against every valid entry (the count entries from head onward, modulo DEPTH), including the head being popped in the same cycle; invalid slots SHALL never match.
REQ-020 A press SHALL be illegal when pressed_lvl >= NUM_LVLS.
REQ-021 A press SHALL be accepted when pressed_en & legal & ~dup & (~full | pop_eff); accepted level written at tail, tail advances by one.
REQ-022 pop_eff = pop & head_valid; pop on empty queue SHALL be ignored with no state change.
REQ-023 Pop SHALL advance head by one; count next = count + accept - pop_eff.
REQ-024 Simultaneous accept and pop_eff when full SHALL leave count at DEPTH and full asserted.
REQ-025 Priority per press: illegal -> req_drop; else dup -> req_dup; else full & ~pop_eff -> req_drop; else req_added; exactly one of the three pulses SHALL assert one cycle after each pressed_en, none otherwise.
REQ-026 flush SHALL set head, tail, count to 0 at the next edge, overriding pop and press; a press in a flush cycle SHALL report req_drop.
REQ-027 head_lvl, head_valid, count, full SHALL be derived from registered state only (no combinational path from inputs).
REQ-028 An entry written in cycle N SHALL be visible to the duplicate check and, if queue was empty, on head_lvl from cycle N+1.

Reset
REQ-029 While rst_n is low at a clock edge, head, tail, count SHALL clear to 0 and req_added, req_dup, req_drop SHALL clear to 0; stored entry data need not clear.
REQ-030 After reset: head_valid=0, head_lvl=0, count=0, full=0; reset mid-operation SHALL discard all entries and any press in that cycle without a pulse.

Verification
REQ-031 Reset, press levels 2,0,3 in consecutive cycles -> three req_added pulses, count=3, head_lvl=2.
REQ-032 Queue {2,0}, press 0 -> req_dup, count stays 2; press 1 -> req_added, count=3.
REQ-033 Fill with 0,1,2,3 -> full=1; press 1 -> req_dup; pop and press 0 together -> req_dup (0 still queued? no, head 0 popped same cycle counts as dup), count=3.
REQ-034 Full queue {0,1,2,3}, pop with press of level 0 vs. legal new level: with NUM_LVLS=8, LVL_W=3, press 5 with pop -> req_added, count=4, head_lvl=1, tail wrapped.
REQ-035 NUM_LVLS=4, LVL_W=3, press 6 -> req_drop, count unchanged; pop on empty -> no change, head_valid=0.
REQ-036 Queue {1,3}, flush with press 2 in same cycle -> count=0, head_valid=0, req_drop; next press 2 -> req_added.
